// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered 8N1 UART transmitter. Bytes enter through a
//             valid/ready handshake, queue in a FIFO and are shifted out
//             LSB first on a registered serial line. Queued frames are sent
//             with no idle gap between them.
//  Ports    : clk_i        - system clock, rising edge
//             rst_i        - synchronous active-high reset
//             tx_data_i    - byte to enqueue
//             tx_valid_i   - tx_data_i valid this cycle
//             tx_ready_o   - FIFO can accept a byte this cycle
//             uart_tx_o    - serial line, idles high
//             busy_o       - frame in progress or FIFO non-empty
//             fifo_count_o - bytes queued, excluding the one being shifted
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  // A one-cycle bit still needs a one-bit counter to keep widths legal.
  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_baud_w-1:0]  r_baud;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_last;
  logic                 w_not_empty;

  // Ready is gated by reset so a byte offered during reset is never taken.
  assign tx_ready_o  = !rst_i && (r_count != c_depth);
  assign w_push      = tx_valid_i && tx_ready_o;
  assign w_baud_last = (r_baud == c_baud_last);
  assign w_not_empty = (r_count != '0);

  // Pop either from idle, or on the last stop cycle so the next start bit
  // follows immediately with no idle gap.
  assign w_pop = w_not_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

  // --------------------------------------------------------------------------
  // FIFO storage: data array needs no reset, push is already blocked in reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter. The line register is loaded with the level of the state
  // being entered, so it changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud    <= '0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx_o    = r_tx;
  assign busy_o       = (r_state != S_IDLE) || w_not_empty;
  assign fifo_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. Accepted bytes go into a
//             scoreboard queue; a line monitor decodes frames and pops and
//             compares them. Scenario tasks check cycle-exact behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        uart_tx_o;
  logic        busy_o;
  logic [4:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;
  int rx_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at cycle idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int p;
    p = idx / CPB;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  // Line monitor: samples on falling edges, decodes mid-bit.
  initial begin : monitor
    int         mcyc;
    bit         mact;
    logic [7:0] mbyte;
    logic [7:0] want;
    mcyc = 0;
    mact = 0;
    mbyte = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        mact = 0;
      end else if (!mact) begin
        if (uart_tx_o === 1'b0) begin
          mact = 1;
          mcyc = 0;
        end
      end else begin
        mcyc++;
      end
      if (mact && !rst_i) begin
        if (mcyc == CPB/2) begin
          checks++;
          if (uart_tx_o !== 1'b0) begin
            errors++;
            $display("FAIL mon_start: got %b expected 0", uart_tx_o);
          end
        end
        if (mcyc >= CPB && mcyc < 9*CPB && (mcyc % CPB) == CPB/2)
          mbyte[mcyc/CPB - 1] = uart_tx_o;
        if (mcyc == 9*CPB + CPB/2) begin
          checks++;
          if (uart_tx_o !== 1'b1) begin
            errors++;
            $display("FAIL mon_stop: got %b expected 1", uart_tx_o);
          end
        end
        if (mcyc == 10*CPB - 1) begin
          mact = 0;
          rx_total++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mon_byte: got %02h expected no frame", mbyte);
          end else begin
            want = exp_q.pop_front();
            if (mbyte !== want) begin
              errors++;
              $display("FAIL mon_byte: got %02h expected %02h", mbyte, want);
            end
          end
        end
      end
    end
  end

  // Drives every byte in pend_q with valid held high, throttled by ready.
  task automatic drive_pending(input int limit);
    int waited;
    waited = 0;
    while (pend_q.size() > 0 && waited <= limit) begin
      @(negedge clk);
      tx_valid_i = 1'b1;
      tx_data_i  = pend_q[0];
      if (tx_ready_o === 1'b1) begin
        exp_q.push_back(pend_q.pop_front());
      end else begin
        waited++;
      end
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (pend_q.size() != 0) begin
      errors++;
      $display("FAIL drive_timeout: got %0d left expected 0", pend_q.size());
      pend_q.delete();
    end
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: got %0d pending busy %b expected 0 pending busy 0",
               exp_q.size(), busy_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i = 8'hEE;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL rst_line: got %b expected 1", uart_tx_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++;
    if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count_o); end
    checks++;
    if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", tx_ready_o); end
    tx_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++;
    if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", tx_ready_o); end
    @(negedge clk);
    checks++;
    if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL rst_push_ignored: got %0d expected 0", fifo_count_o); end
  endtask

  task automatic test_single;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", fifo_count_o); end
    checks++;
    if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", uart_tx_o); end
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk);
      checks++;
      if (uart_tx_o !== frame_bit(8'h55, k)) begin
        errors++;
        $display("FAIL single_line[%0d]: got %b expected %b", k, uart_tx_o, frame_bit(8'h55, k));
      end
      if (k == 0) begin
        checks++;
        if (fifo_count_o !== 5'd0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL single_pop: got count %0d busy %b expected 0 1", fifo_count_o, busy_o);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
      errors++;
      $display("FAIL single_end: got busy %b line %b expected 0 1", busy_o, uart_tx_o);
    end
    wait_drain(20);
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    checks++;
    if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", tx_ready_o); end
    tx_data_i = 8'h3C;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 5'd1) begin errors++; $display("FAIL b2b_count1: got %0d expected 1", fifo_count_o); end
    for (int k = 0; k < 20*CPB; k++) begin
      if (k > 0) @(negedge clk);
      b = (k < 10*CPB) ? 8'hA5 : 8'h3C;
      checks++;
      if (uart_tx_o !== frame_bit(b, k % (10*CPB))) begin
        errors++;
        $display("FAIL b2b_line[%0d]: got %b expected %b", k, uart_tx_o, frame_bit(b, k % (10*CPB)));
      end
      if (k == 10*CPB) begin
        checks++;
        if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL b2b_count0: got %0d expected 0", fifo_count_o); end
      end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: got busy %b line %b expected 0 1", busy_o, uart_tx_o);
    end
    wait_drain(20);
  endtask

  task automatic test_full;
    int w;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i = 8'hF0;
    exp_q.push_back(8'hF0);
    @(negedge clk);
    tx_valid_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge clk);
      tx_valid_i = 1'b1;
      tx_data_i = 8'h80 + 8'(i);
      checks++;
      if (fifo_count_o !== 5'(i) || tx_ready_o !== (i < DEPTH)) begin
        errors++;
        $display("FAIL full_fill[%0d]: got count %0d ready %b expected %0d %b",
                 i, fifo_count_o, tx_ready_o, i, (i < DEPTH));
      end
      if (tx_ready_o === 1'b1) exp_q.push_back(tx_data_i);
    end
    w = 0;
    while (tx_ready_o !== 1'b1 && w < 20*CPB) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (tx_ready_o !== 1'b1 || fifo_count_o !== 5'd15) begin
      errors++;
      $display("FAIL full_reopen: got ready %b count %0d expected 1 15", tx_ready_o, fifo_count_o);
    end
    if (tx_ready_o === 1'b1) exp_q.push_back(tx_data_i);
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 5'd16) begin errors++; $display("FAIL full_17th: got %0d expected 16", fifo_count_o); end
    wait_drain(20*10*CPB);
  endtask

  task automatic test_wrap;
    int start;
    start = rx_total;
    for (int i = 0; i < 40; i++) pend_q.push_back(8'(i));
    drive_pending(50*10*CPB);
    wait_drain(20*10*CPB);
    checks++;
    if (rx_total - start != 40) begin
      errors++;
      $display("FAIL wrap_total: got %0d expected 40", rx_total - start);
    end
  endtask

  task automatic test_simul;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h11;
    exp_q.push_back(8'h11);
    @(negedge clk);
    tx_data_i = 8'h22;
    exp_q.push_back(8'h22);
    @(negedge clk);
    tx_valid_i = 1'b0;
    repeat (10*CPB - 1) @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h7E;
    checks++;
    if (tx_ready_o !== 1'b1 || fifo_count_o !== 5'd1) begin
      errors++;
      $display("FAIL simul_pre: got ready %b count %0d expected 1 1", tx_ready_o, fifo_count_o);
    end
    exp_q.push_back(8'h7E);
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 5'd1 || uart_tx_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_post: got count %0d line %b expected 1 0", fifo_count_o, uart_tx_o);
    end
    wait_drain(4*10*CPB);
  endtask

  task automatic test_reset_mid;
    int start;
    int lows;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_valid_i = 1'b1;
      tx_data_i = 8'hC0 + 8'(i);
      exp_q.push_back(tx_data_i);
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 5'd5) begin errors++; $display("FAIL rmid_count5: got %0d expected 5", fifo_count_o); end
    repeat (13) @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (uart_tx_o !== 1'b1 || fifo_count_o !== 5'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: got line %b count %0d busy %b expected 1 0 0",
               uart_tx_o, fifo_count_o, busy_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    start = rx_total;
    lows = 0;
    repeat (25*CPB) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0 || rx_total != start) begin
      errors++;
      $display("FAIL rmid_quiet: got %0d active cycles %0d frames expected 0 0", lows, rx_total - start);
    end
    pend_q.push_back(8'h5A);
    drive_pending(10);
    wait_drain(3*10*CPB);
    checks++;
    if (rx_total - start != 1) begin
      errors++;
      $display("FAIL rmid_recover: got %0d frames expected 1", rx_total - start);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_i = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_simul();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter, the send-side counterpart to the board's UART receive path. It accepts bytes from on-chip logic through a valid/ready handshake and queues them in an internal FIFO. It serialises them onto the UART TX pin, LSB first, with no idle gap between queued frames. It sits between application logic (echo, status reporting) and the `uart_tx_pin_o` top-level pin.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per UART bit; 234 gives ≈115200 baud at 27 MHz. Legal range ≥1.
- `FIFO_DEPTH`, 16: byte entries in the queue; power of two, ≥2.
- `clk_i`  input  1  single system clock; all logic on rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `tx_data_i`  input  8  byte to enqueue.
- `tx_valid_i`  input  1  `tx_data_i` is valid this cycle.
- `tx_ready_o`  output  1  FIFO can accept a byte this cycle.
- `uart_tx_o`  output  1  serial line; idles high.
- `busy_o`  output  1  a frame is in progress or the FIFO is non-empty.
- `fifo_count_o`  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

## Operation
- Push: a byte is written on any edge where `tx_valid_i && tx_ready_o`.
- `tx_ready_o = !rst_i && (fifo_count_o != FIFO_DEPTH)`. It is combinational from registered count. There is no pass-through when full: a simultaneous pop does not make a full FIFO ready.
- FIFO read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo depth. The count is one bit wider, so full and empty are unambiguous.
- Transmitter FSM has four states:
  - IDLE: line held at 1.
  - START: line at 0.
  - DATA: line follows `shift[0]`; 8 bits, LSB first.
  - STOP: line at 1.
- Each state other than IDLE lasts exactly `CLKS_PER_BIT` cycles. A baud counter runs from 0 to `CLKS_PER_BIT-1`. A bit index runs from 0 to 7 in DATA.
- IDLE → START: on an edge in IDLE with count ≠ 0, pop the head into the shift register.
- DATA advances: after 8 bit periods, go to STOP.
- STOP → next frame: on the last STOP cycle, if count ≠ 0, pop and go straight to START (back-to-back). Otherwise go to IDLE.
- Simultaneous push and pop in one cycle: both succeed and the count is unchanged. This also holds at count = 1 (head popped, new byte becomes head).
- `uart_tx_o` is driven from a register, so the line is glitch-free.
- `busy_o = (state != IDLE) || (count != 0)`.

## Timing
- Reset values (edge after `rst_i` sampled high):
  - `uart_tx_o` = 1
  - `busy_o` = 0
  - `fifo_count_o` = 0
  - FSM = IDLE
  - pointers and counters = 0
  - `tx_ready_o` = 0 while `rst_i` is high, and 1 in the first cycle after.
- Reset mid-frame aborts the frame: the line returns high on the reset edge, and queued bytes are discarded. A push in the reset cycle is ignored.
- Latency into an idle block:
  - Byte pushed at edge E: count = 1 after E.
  - Pop at edge E+1: FSM enters START.
  - `uart_tx_o` falls after edge E+1. The line is registered from next-state, so there is exactly 1 cycle from the push edge to the start bit.
- Frame length: exactly `10*CLKS_PER_BIT` cycles (start + 8 data + stop).
- Queued frames are contiguous: the next start bit begins on the cycle after the last stop-bit cycle.
- Throughput: one byte per `10*CLKS_PER_BIT` cycles. The FIFO absorbs bursts up to `FIFO_DEPTH` bytes, plus one more in the shift register.
- `CLKS_PER_BIT = 1`: every bit lasts one cycle; the baud counter is a constant, and the rules above still hold.

## Test plan
- Single byte, `CLKS_PER_BIT=4`: push 0x55 into an idle block. The line shows 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles. `busy_o` drops the cycle after the stop bit ends.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles. Exactly 80 cycles of framing follow with no idle gap. The decoded bytes are 0xA5 then 0x3C. `fifo_count_o` reads 1 after the second push, then 0 after the second pop.
- Full: push 17 bytes with `tx_valid_i` held high while the transmitter is busy. 16 are accepted and `tx_ready_o` goes low at count 16. The 17th is not taken until the next pop. All accepted bytes are sent in order.
- Pointer wrap: stream 40 bytes (0x00–0x27) with `FIFO_DEPTH=16`, throttled by `tx_ready_o`. The output sequence is identical to the input, with no loss or duplicates.
- Simultaneous push/pop: with count = 1 and the current frame on its last stop cycle, push 0x7E. The count stays 1, the head byte starts transmitting, and 0x7E becomes the new head.
- Reset mid-frame: assert `rst_i` during DATA bit 3 with 5 bytes queued. After the reset edge: `uart_tx_o`=1, count=0, `busy_o`=0. No further frames are emitted until a new push.
